// File: rtl/epu_pkg.sv
// epu_pkg: shared instruction-type codes, NOP defaults and hazard FSM state encoding
package epu_pkg;
    localparam logic [6:0]  LOAD     = 7'b0000011;
    localparam logic [6:0]  ADDI     = 7'b0010011;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;
    localparam logic [31:0] NOP_INS  = 32'h0000_0013;
    localparam logic [6:0]  NOP_TYPE = ADDI;
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } hz_state_e;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the rd of a load still in EX
//   ex_ins_type/ex_rd_addr : instruction type and destination held in ID/EX
//   id_r*_addr/id_r*_used  : ID-stage source registers and their read enables
//   hazard                 : 1 when a one-cycle bubble is needed
module load_use_detect
    import epu_pkg::*;
(
    input  logic [6:0] ex_ins_type,
    input  logic [4:0] ex_rd_addr,
    input  logic [4:0] id_r1_addr,
    input  logic       id_r1_used,
    input  logic [4:0] id_r2_addr,
    input  logic       id_r2_used,
    output logic       hazard
);
    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = (ex_ins_type == LOAD) && (ex_rd_addr != 5'd0) &&
                    ((id_r1_used && id_r1_addr == ex_rd_addr) ||
                     (id_r2_used && id_r2_addr == ex_rd_addr));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use and control hazards in the 5-stage pipeline
//   clk_in, rst_in (sync, active-high), rdy_in (0 freezes everything)
//   id_r1/r2_addr/used, ex_ins_type, ex_rd_addr : load-use detection inputs
//   ex_branch_taken, mem_busy, if_busy          : control / memory events
//   stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex : pipeline strobes
//   perf_stall_cnt, perf_flush_cnt : counters, live only when PIPE_PERF_CNT_EN is defined
module pipe_hazard_ctrl
    import epu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [4:0]           id_r1_addr,
    input  logic                 id_r1_used,
    input  logic [4:0]           id_r2_addr,
    input  logic                 id_r2_used,
    input  logic [6:0]           ex_ins_type,
    input  logic [4:0]           ex_rd_addr,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    input  logic                 if_busy,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 clear_if_id,
    output logic                 clear_id_ex,
    output logic [CNT_WIDTH-1:0] perf_stall_cnt,
    output logic [CNT_WIDTH-1:0] perf_flush_cnt
);
    localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic       MULTI    = FLUSH_CYCLES > 1;

    hz_state_e  state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       pend, pend_n;
    logic       lu_hazard, stall_all, br_apply;

    load_use_detect u_lud (
        .ex_ins_type (ex_ins_type),
        .ex_rd_addr  (ex_rd_addr),
        .id_r1_addr  (id_r1_addr),
        .id_r1_used  (id_r1_used),
        .id_r2_addr  (id_r2_addr),
        .id_r2_used  (id_r2_used),
        .hazard      (lu_hazard)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        pend_n      = pend;
        stall_all   = 1'b0;
        br_apply    = 1'b0;
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        clear_if_id = 1'b0;
        clear_id_ex = 1'b0;
        if (rst_in) begin
            clear_if_id = 1'b1;
            clear_id_ex = 1'b1;
        end else if (!rdy_in) begin
            stall_all = 1'b1;
        end else if (state == ST_FLUSH) begin
            if (mem_busy) begin
                stall_all = 1'b1;
            end else if (ex_branch_taken) begin
                br_apply    = 1'b1;
                clear_if_id = 1'b1;
                clear_id_ex = 1'b1;
                cnt_n       = CNT_LOAD;
                state_n     = MULTI ? ST_FLUSH : ST_RUN;
            end else begin
                clear_if_id = 1'b1;
                cnt_n       = cnt - 3'd1;
                state_n     = (cnt == 3'd1) ? ST_RUN : ST_FLUSH;
            end
        end else if (mem_busy) begin
            // a branch resolving while memory is stalled is remembered and applied on release
            stall_all = 1'b1;
            state_n   = ST_MEM_WAIT;
            pend_n    = pend | ex_branch_taken;
        end else if (ex_branch_taken || pend) begin
            br_apply    = 1'b1;
            pend_n      = 1'b0;
            clear_if_id = 1'b1;
            clear_id_ex = 1'b1;
            cnt_n       = CNT_LOAD;
            state_n     = MULTI ? ST_FLUSH : ST_RUN;
        end else begin
            state_n = ST_RUN;
            if (lu_hazard) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                clear_id_ex = 1'b1;
            end else if (if_busy) begin
                clear_if_id = 1'b1;
            end
        end
        stall_pc     = stall_pc | stall_all;
        stall_if_id  = stall_if_id | stall_all;
        stall_id_ex  = stall_all;
        stall_ex_mem = stall_all;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
            pend  <= 1'b0;
        end else if (rdy_in) begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
        end
    end

    // after IF/ID and ID/EX are cleared, EX cannot hold another taken branch during refill
    assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && state == ST_FLUSH && !mem_busy && ex_branch_taken));

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_pc && rdy_in) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (br_apply) perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end
`else
    assign perf_stall_cnt = CNT_WIDTH'(ZeroWord);
    assign perf_flush_cnt = CNT_WIDTH'(ZeroWord);
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors for pipe_hazard_ctrl with FLUSH_CYCLES=3
module tb_pipe_hazard_ctrl;
    import epu_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, id_r1_used, id_r2_used, ex_branch_taken, mem_busy, if_busy;
    logic [4:0]  id_r1_addr, id_r2_addr, ex_rd_addr;
    logic [6:0]  ex_ins_type;
    logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
    logic [31:0] exp_stall, exp_flush;
    int          n_tests = 0, n_fail = 0;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .id_r1_addr(id_r1_addr), .id_r1_used(id_r1_used),
        .id_r2_addr(id_r2_addr), .id_r2_used(id_r2_used),
        .ex_ins_type(ex_ins_type), .ex_rd_addr(ex_rd_addr),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy), .if_busy(if_busy),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
        .stall_ex_mem(stall_ex_mem), .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs: rdy, mem_busy, branch, if_busy, ex is load, ex rd, rs1, rs1 used, rs2, rs2 used
    task automatic drive(input logic rdy, input logic mb, input logic br, input logic ifb,
                         input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                         input logic r1u, input logic [4:0] r2, input logic r2u);
        rdy_in = rdy; mem_busy = mb; ex_branch_taken = br; if_busy = ifb;
        ex_ins_type = ld ? LOAD : ADDI; ex_rd_addr = rd;
        id_r1_addr = r1; id_r1_used = r1u; id_r2_addr = r2; id_r2_used = r2u;
    endtask

    // expected order {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex}
    task automatic cyc(input string tag, input logic [5:0] exp);
        #1;
        check(tag, {26'd0, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, clear_if_id, clear_id_ex},
              {26'd0, exp});
        if (!rst_in && rdy_in && exp[5]) exp_stall++;
        if (!rst_in && rdy_in && exp == 6'b000011) exp_flush++;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPE_PERF_CNT_EN
        check({tag, "_stall"}, perf_stall_cnt, exp_stall);
        check({tag, "_flush"}, perf_flush_cnt, exp_flush);
`else
        check({tag, "_stall"}, perf_stall_cnt, 32'd0);
        check({tag, "_flush"}, perf_flush_cnt, 32'd0);
`endif
    endtask

    initial begin
        rst_in = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_stall = 0; exp_flush = 0;
        @(posedge clk_in); #1;
        cyc("reset", 6'b000011);
        rst_in = 1'b0;
        check_perf("perf_reset");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("idle", 6'b000000);
        drive(1, 0, 0, 0, 1, 5, 5, 1, 0, 0); cyc("lu_rs1", 6'b110001);
        drive(1, 0, 0, 0, 0, 5, 5, 1, 0, 0); cyc("lu_flow", 6'b000000);
        drive(1, 0, 0, 0, 1, 7, 3, 1, 7, 1); cyc("lu_rs2", 6'b110001);
        drive(1, 0, 0, 0, 1, 7, 3, 1, 7, 0); cyc("lu_rs2_unused", 6'b000000);
        drive(1, 0, 0, 0, 1, 0, 0, 1, 0, 1); cyc("lu_x0", 6'b000000);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("if_busy", 6'b000010);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("br_c0", 6'b000011);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("br_c1", 6'b000010);
        cyc("br_c2", 6'b000010);
        drive(1, 0, 0, 0, 1, 5, 5, 1, 0, 0); cyc("br_run", 6'b110001);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mb_c1", 6'b111100);
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); cyc("mb_c2_br", 6'b111100);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mb_c3", 6'b111100);
        cyc("mb_c4", 6'b111100);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mb_pend_br", 6'b000011);
        cyc("mb_fl1", 6'b000010);
        cyc("mb_fl2", 6'b000010);
        cyc("mb_run", 6'b000000);
        drive(1, 0, 0, 1, 0, 0, 0, 0, 0, 0); cyc("mw_exit_ifb_pre", 6'b000010);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("mw_enter", 6'b111100);
        drive(1, 0, 0, 0, 1, 9, 0, 0, 9, 1); cyc("mw_exit_lu", 6'b110001);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("fmb_br", 6'b000011);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); cyc("fmb_hold", 6'b111100);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("fmb_fl1", 6'b000010);
        cyc("fmb_fl2", 6'b000010);
        cyc("fmb_run", 6'b000000);
        drive(0, 0, 0, 0, 1, 5, 5, 1, 0, 0); cyc("rdy0_lu_a", 6'b111100);
        cyc("rdy0_lu_b", 6'b111100);
        drive(1, 0, 0, 0, 1, 5, 5, 1, 0, 0); cyc("rdy1_lu", 6'b110001);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("rdy0_br", 6'b111100);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); cyc("rdy0_br_ignored", 6'b000000);
        check_perf("perf_mid");
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0); cyc("rst_br", 6'b000011);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_in = 1'b1;
        exp_stall = 0; exp_flush = 0;
        cyc("rst_mid_flush", 6'b000011);
        rst_in = 1'b0;
        check_perf("perf_after_rst");
        cyc("rst_run", 6'b000000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
